riscv_multicycle_control: RTL and testbench
===========================================

# riscv_multicycle_control

Multi-cycle main control unit for the RV32I datapath. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles. Memory access uses a request/ready handshake with a wait-state timeout, and the unit traps on illegal opcodes. It also keeps a retired-instruction counter. The unit sits between the instruction register (opcode field) and the shared-memory multi-cycle datapath.

## Interface
- `TIMEOUT_CYCLES`, 15: maximum wait cycles for `mem_ready` per access before trapping (≥1).
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: instruction-register bits [6:0], valid from DECODE onward.
- `zero` in 1: ALU zero flag, used in BRANCH.
- `mem_ready` in 1: memory accepts/completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request (store).
- `addr_src` out 1: 0 = PC, 1 = ALU-out register.
- `ir_write` out 1: latch instruction and old PC.
- `pc_write` out 1: PC update enable.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `result_src` out 2: 00 = ALU-out register, 01 = memory data, 10 = ALU result.
- `reg_write` out 1: register-file write enable.
- `branch` out 1: branch-evaluation cycle.
- `trap` out 1: sticky fault flag.
- `illegal` out 1: sticky, trap caused by opcode.
- `timeout` out 1: sticky, trap caused by memory wait.
- `instret` out CNT_W: retired instructions.
- `state` out 4: current state (debug).

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP.
- FETCH: `mem_req`=1, `addr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00. Once `mem_ready`=1, the same cycle asserts `ir_write`=1 and `pc_write`=1 (PC+4), then the next state is DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (branch target). Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → TRAP with `illegal`=1
- MEM_ADDR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Load → MEM_READ, store → MEM_WRITE.
- MEM_READ / MEM_WRITE: `mem_req`=1, `addr_src`=1; MEM_WRITE also drives `mem_we`=1. On `mem_ready`, MEM_READ → MEM_WB and MEM_WRITE → FETCH.
- MEM_WB: `result_src`=01, `reg_write`=1, then → FETCH.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10, then → ALU_WB.
- EXEC_I: same as EXEC_R except `alu_src_b`=01, then → ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`=1, then → FETCH.
- BRANCH: `branch`=1, `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=`zero`, then → FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1, then → ALU_WB.
- TRAP: all control outputs are 0 and `trap`=1. The state is held until reset.
- All unlisted outputs are 0 in every state.
- `instret` increments by 1 on every transition into FETCH from any state other than FETCH; it wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore-decoded from `state`. The exceptions are `ir_write`/`pc_write` in FETCH (gated by `mem_ready`) and `pc_write` in BRANCH (gated by `zero`).
- Reset: while `rst_n`=0 at a rising edge, the next state is FETCH and `instret`, the wait counter, `trap`, `illegal` and `timeout` are cleared. Reset taken mid-access abandons the access.
- Cycles per instruction, with zero wait states:
  - R-type and I-type: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
- Each wait cycle adds 1.
- Wait counter:
  - Cleared on entry to any memory state.
  - Increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When it reaches TIMEOUT_CYCLES with `mem_ready` still 0 → TRAP with `timeout`=1.
  - If `mem_ready`=1 arrives in the same cycle the counter reaches the limit, completion wins.
- `mem_req`, `mem_we` and `addr_src` are held stable from the start of a request until the `mem_ready` cycle.

## Structure
- Package `riscv_ctrl_pkg`:
  - opcode constants for R, I, L, S, B and JAL
  - state enum (4-bit)
  - encodings for `alu_src_a`/`alu_src_b`/`alu_op`/`result_src`
- One sub-module, `riscv_mem_wait_timer`: wait counter and timeout compare, parameterised by TIMEOUT_CYCLES.

## Test plan
- Reset then R-type (0110011), `mem_ready` tied 1 → states FETCH, DECODE, EXEC_R, ALU_WB; `reg_write`=1 only in the 4th cycle; `instret`=1.
- Load (0000011), `mem_ready` low for 3 cycles at fetch → 8 cycles total; `result_src`=01 with `reg_write`=1 in MEM_WB.
- Branch (1100011) with `zero`=1, then with `zero`=0 → `pc_write`=1 in BRANCH for the first, 0 for the second; both 3 cycles.
- Opcode 1111111 → TRAP after DECODE with `illegal`=1 and `trap`=1; all control outputs 0 for 20+ cycles; `rst_n`=0 clears the flags.
- Store with `mem_ready` stuck 0 and TIMEOUT_CYCLES=15 → `timeout`=1 after 15 wait cycles; `mem_we` is 0 in TRAP.
- CNT_W=4, run 17 instructions → `instret`=1 after wrap; assert `rst_n`=0 during MEM_READ → FETCH the next cycle with `instret`=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control unit: opcodes, FSM states
// and datapath mux / ALU-op encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_TRAP      = 4'd11
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/riscv_multicycle_control_if.sv
// Memory request/ready handshake between the control unit (master) and the
// shared instruction/data memory (slave).
interface riscv_multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic addr_src;
    logic mem_ready;

    modport master (output mem_req, mem_we, addr_src, input mem_ready);
    modport slave  (input mem_req, mem_we, addr_src, output mem_ready);
endinterface

// File: rtl/riscv_mem_wait_timer.sv
// Per-access wait-state counter. Expires when a request is still unanswered in
// the cycle the count already equals TIMEOUT_CYCLES; a ready in that cycle wins.
module riscv_mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ready_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle without an outstanding wait returns the count to zero, so each
    // new access starts fresh.
    always_comb begin
        cnt_d = '0;
        if (req_i && !ready_i && cnt_q != LIMIT)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = req_i && !ready_i && (cnt_q == LIMIT);

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/
// write-back, traps on illegal opcodes or memory timeouts, counts retirements.
module riscv_multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [6:0]                 opcode,
    input  logic                       zero,
    riscv_multicycle_control_if.master mem,
    output logic                       ir_write,
    output logic                       pc_write,
    output logic [1:0]                 alu_src_a,
    output logic [1:0]                 alu_src_b,
    output logic [1:0]                 alu_op,
    output logic [1:0]                 result_src,
    output logic                       reg_write,
    output logic                       branch,
    output logic                       trap,
    output logic                       illegal,
    output logic                       timeout,
    output logic [CNT_W-1:0]           instret,
    output logic [3:0]                 state
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             trap_q, illegal_q, timeout_q;
    logic             mem_req, mem_we, addr_src;
    logic             expired, illegal_set;

    riscv_mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (mem_req),
        .ready_i   (mem.mem_ready),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_src    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALU_ADD;
        result_src  = RES_ALUOUT;
        reg_write   = 1'b0;
        branch      = 1'b0;
        illegal_set = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_R:        state_d = S_EXEC_R;
                    OP_I:        state_d = S_EXEC_I;
                    OP_L, OP_S:  state_d = S_MEM_ADDR;
                    OP_B:        state_d = S_BRANCH;
                    OP_JAL:      state_d = S_JAL;
                    default: begin
                        state_d     = S_TRAP;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_d   = (opcode == OP_L) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem.mem_ready) state_d = S_MEM_WB;
                else if (expired)  state_d = S_TRAP;
            end
            S_MEM_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem.mem_ready) state_d = S_FETCH;
                else if (expired)  state_d = S_TRAP;
            end
            S_MEM_WB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                branch     = 1'b1;
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALU-out; the ALU forms the link value
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALU_WB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_FETCH && state_q != S_FETCH)
                instret_q <= instret_q + CNT_W'(1);
            if (state_d == S_TRAP) trap_q    <= 1'b1;
            if (illegal_set)       illegal_q <= 1'b1;
            if (expired)           timeout_q <= 1'b1;
        end
    end

    assign mem.mem_req  = mem_req;
    assign mem.mem_we   = mem_we;
    assign mem.addr_src = addr_src;
    assign trap         = trap_q;
    assign illegal      = illegal_q;
    assign timeout      = timeout_q;
    assign instret      = instret_q;
    assign state        = state_q;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench for riscv_multicycle_control: instruction table plus hand
// sequences for wrap, mid-access reset, illegal trap and memory timeout.
module tb_riscv_multicycle_control;

    localparam int TO = 15;
    localparam int CW = 4;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_READ = 4'd3,
                           ST_MEM_WRITE = 4'd5, ST_TRAP = 4'd11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          zero = 1'b0;
    logic          ir_write, pc_write, reg_write, branch, trap, illegal, timeout;
    logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
    logic [CW-1:0] instret;
    logic [3:0]    state;

    riscv_multicycle_control_if mif();

    riscv_multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem(mif),
        .ir_write(ir_write), .pc_write(pc_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .reg_write(reg_write), .branch(branch), .trap(trap), .illegal(illegal),
        .timeout(timeout), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rdy);
        mif.mem_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [14:0] ctrl_bits();
        return {mif.mem_req, mif.mem_we, mif.addr_src, ir_write, pc_write,
                alu_src_a, alu_src_b, alu_op, result_src, reg_write, branch};
    endfunction

    // Runs one instruction from FETCH back to FETCH; fw/mw are wait cycles
    // inserted before ready on the fetch and data accesses.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                             output int cyc, output logic [7:0][3:0] tr, output int rw,
                             output int pw, output int we, output logic [3:0] rm);
        int wc;
        bit left;
        wc = 0; left = 1'b0;
        cyc = 0; tr = '0; rw = 0; pw = 0; we = 0; rm = '0;
        opcode = op;
        zero   = z;
        while (!(left && state == ST_FETCH) && cyc < 200) begin
            if (mif.mem_req) begin
                if (wc < ((state == ST_FETCH) ? fw : mw)) begin
                    mif.mem_ready = 1'b0;
                    wc++;
                end else begin
                    mif.mem_ready = 1'b1;
                    wc = 0;
                end
            end else begin
                mif.mem_ready = 1'b0;
            end
            #1;
            if (cyc < 8) tr[cyc] = state;
            rw += int'(reg_write);
            pw += int'(pc_write);
            we += int'(mif.mem_we);
            if (reg_write) rm[result_src] = 1'b1;
            if (state != ST_FETCH) left = 1'b1;
            cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        mif.mem_ready = 1'b0;
    endtask

    typedef struct {
        logic [6:0]      op;
        logic            z;
        int              fw;
        int              mw;
        int              cyc;
        logic [7:0][3:0] tr;   // state per cycle, cycle 0 in the low nibble
        int              rw;
        int              pw;
        int              we;
        logic [3:0]      rm;   // one-hot set of result_src values used while reg_write
        logic [CW-1:0]   ir;
    } vec_t;

    vec_t vt[10];

    initial begin
        int            cyc, rw, pw, we, bad, n;
        logic [7:0][3:0] tr;
        logic [3:0]    rm;

        vt[0] = '{7'b0110011, 1'b0, 0, 0,  4, 32'h00008610, 1, 1,  0, 4'b0001, 4'd1};
        vt[1] = '{7'b0010011, 1'b0, 0, 0,  4, 32'h00008710, 1, 1,  0, 4'b0001, 4'd2};
        vt[2] = '{7'b0000011, 1'b0, 3, 0,  8, 32'h43210000, 1, 1,  0, 4'b0010, 4'd3};
        vt[3] = '{7'b0000011, 1'b0, 0, 2,  7, 32'h04333210, 1, 1,  0, 4'b0010, 4'd4};
        vt[4] = '{7'b0100011, 1'b0, 0, 0,  4, 32'h00005210, 0, 1,  1, 4'b0000, 4'd5};
        vt[5] = '{7'b0100011, 1'b0, 0, 1,  5, 32'h00055210, 0, 1,  2, 4'b0000, 4'd6};
        vt[6] = '{7'b1100011, 1'b1, 0, 0,  3, 32'h00000910, 0, 2,  0, 4'b0000, 4'd7};
        vt[7] = '{7'b1100011, 1'b0, 0, 0,  3, 32'h00000910, 0, 1,  0, 4'b0000, 4'd8};
        vt[8] = '{7'b1101111, 1'b0, 0, 0,  4, 32'h00008A10, 1, 2,  0, 4'b0001, 4'd9};
        // ready arrives exactly in the limit cycle of a store: completion wins
        vt[9] = '{7'b0100011, 1'b0, 2, TO, 21, 32'h55521000, 0, 1, 16, 4'b0000, 4'd10};

        mif.mem_ready = 1'b0;
        @(negedge clk);
        step(1'b0);
        step(1'b0);
        chk("reset state", 32'(state), 32'(ST_FETCH));
        chk("reset instret", 32'(instret), 0);
        chk("reset flags", {29'd0, trap, illegal, timeout}, 0);
        chk("reset fetch req", {31'd0, mif.mem_req}, 1);
        chk("reset ir_write gated", {31'd0, ir_write}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_instr(vt[i].op, vt[i].z, vt[i].fw, vt[i].mw, cyc, tr, rw, pw, we, rm);
            chk($sformatf("v%0d cycles", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d trace", i), tr, vt[i].tr);
            chk($sformatf("v%0d reg_write", i), rw, vt[i].rw);
            chk($sformatf("v%0d pc_write", i), pw, vt[i].pw);
            chk($sformatf("v%0d mem_we", i), we, vt[i].we);
            chk($sformatf("v%0d result_src", i), 32'(rm), 32'(vt[i].rm));
            chk($sformatf("v%0d instret", i), 32'(instret), 32'(vt[i].ir));
        end

        // seven more R-types: 17 retirements total wraps the 4-bit counter to 1
        for (int k = 0; k < 7; k++)
            run_instr(7'b0110011, 1'b0, 0, 0, cyc, tr, rw, pw, we, rm);
        chk("instret wrap", 32'(instret), 1);

        opcode = 7'b0000011;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("midreset in MEM_READ", 32'(state), 32'(ST_MEM_READ));
        chk("midreset req/addr", {30'd0, mif.mem_req, mif.addr_src}, 32'h3);
        rst_n = 1'b0;
        step(1'b0);
        chk("midreset state", 32'(state), 32'(ST_FETCH));
        chk("midreset instret", 32'(instret), 0);
        rst_n = 1'b1;

        opcode = 7'b1111111;
        step(1'b1);
        chk("illegal decode", 32'(state), 32'(ST_DECODE));
        step(1'b0);
        chk("illegal state", 32'(state), 32'(ST_TRAP));
        chk("illegal flags", {29'd0, trap, illegal, timeout}, 32'h6);
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            zero = k[0];
            step(1'($urandom_range(0, 1)));
            if (ctrl_bits() != '0 || state != ST_TRAP || trap !== 1'b1) bad++;
        end
        chk("trap hold outputs", bad, 0);
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        chk("illegal cleared", {29'd0, trap, illegal, timeout}, 0);
        chk("illegal reset state", 32'(state), 32'(ST_FETCH));

        opcode = 7'b0100011;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("timeout in MEM_WRITE", 32'(state), 32'(ST_MEM_WRITE));
        n = 0;
        while (state == ST_MEM_WRITE && n < 100) begin
            n++;
            step(1'b0);
        end
        chk("timeout wait cycles", n, TO + 1);
        chk("timeout state", 32'(state), 32'(ST_TRAP));
        chk("timeout flags", {29'd0, trap, illegal, timeout}, 32'h5);
        chk("timeout mem_we/req", {30'd0, mif.mem_we, mif.mem_req}, 0);
        rst_n = 1'b0;
        step(1'b0);
        rst_n = 1'b1;
        chk("timeout cleared", {29'd0, trap, illegal, timeout}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
